// File: rtl/rpm_pulse_cond_pkg.sv
// Shared constants and state encoding for the tachometer input conditioner.
package rpm_pulse_cond_pkg;

    localparam int RPM_WIDTH         = 16;
    localparam int RPM_DEB_DEFAULT   = 4;
    localparam int RPM_STALL_DEFAULT = 65535;

    typedef enum logic [1:0] {
        ST_LOW     = 2'd0,
        ST_QUAL_HI = 2'd1,
        ST_HIGH    = 2'd2,
        ST_QUAL_LO = 2'd3
    } cond_state_t;

endpackage

// File: rtl/rpm_sync.sv
// N-stage resettable synchroniser for asynchronous single-bit inputs.
// Latency STAGES cycles; no backpressure.
module rpm_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ff <= {STAGES{RESET_VAL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/rpm_pulse_cond.sv
// Sensor conditioner: sync, debounce, edge strobe, stall detect, glitch count.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES cycles to pulse; no backpressure.
module rpm_pulse_cond
    import rpm_pulse_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = RPM_DEB_DEFAULT,
    parameter int STALL_CYCLES    = RPM_STALL_DEFAULT,
    parameter int EDGE            = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sensor_in,
    input  logic       en,
    output logic       pulse,
    output logic       level,
    output logic       stalled,
    output logic [7:0] glitch_cnt
);

    localparam logic [7:0]           DEB_LIM   = 8'(DEBOUNCE_CYCLES);
    localparam logic [RPM_WIDTH-1:0] STALL_LIM = RPM_WIDTH'(STALL_CYCLES);

    logic                 s;
    cond_state_t          state;
    logic [7:0]           deb_cnt;
    logic [RPM_WIDTH-1:0] stall_cnt;
    logic                 acc_rise;
    logic                 acc_fall;
    logic                 pulse_set;

    rpm_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (sensor_in),
        .q       (s)
    );

    always_comb begin
        acc_rise  = (state == ST_QUAL_HI) && s  && (deb_cnt == DEB_LIM);
        acc_fall  = (state == ST_QUAL_LO) && !s && (deb_cnt == DEB_LIM);
        pulse_set = en && ((EDGE != 0) ? acc_rise : acc_fall);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_LOW;
            deb_cnt    <= 8'd0;
            level      <= 1'b0;
            pulse      <= 1'b0;
            glitch_cnt <= 8'd0;
        end else begin
            pulse <= pulse_set;
            case (state)
                ST_LOW: begin
                    if (s) begin
                        state   <= ST_QUAL_HI;
                        deb_cnt <= 8'd1;
                    end
                end
                ST_QUAL_HI: begin
                    if (s) begin
                        if (deb_cnt == DEB_LIM) begin
                            state <= ST_HIGH;
                            level <= 1'b1;
                        end else begin
                            deb_cnt <= deb_cnt + 8'd1;
                        end
                    end else begin
                        state <= ST_LOW;
                        if (glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 8'd1;
                    end
                end
                ST_HIGH: begin
                    if (!s) begin
                        state   <= ST_QUAL_LO;
                        deb_cnt <= 8'd1;
                    end
                end
                ST_QUAL_LO: begin
                    if (!s) begin
                        if (deb_cnt == DEB_LIM) begin
                            state <= ST_LOW;
                            level <= 1'b0;
                        end else begin
                            deb_cnt <= deb_cnt + 8'd1;
                        end
                    end else begin
                        state <= ST_HIGH;
                        if (glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 8'd1;
                    end
                end
                default: state <= ST_LOW;
            endcase
        end
    end

    // An accepted pulse beats saturation in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            stalled   <= 1'b0;
        end else if (!en || pulse_set) begin
            stall_cnt <= '0;
            stalled   <= 1'b0;
        end else if (stall_cnt != STALL_LIM) begin
            stall_cnt <= stall_cnt + 1'b1;
            stalled   <= (stall_cnt + 1'b1) == STALL_LIM;
        end
    end

endmodule

// File: tb/tb_rpm_pulse_cond.sv
// Directed bench for rpm_pulse_cond; expected pulse cycles go through a scoreboard queue.
`timescale 1ns/1ps
module tb_rpm_pulse_cond;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       sensor_in;
    logic       en;
    logic       pulse;
    logic       level;
    logic       stalled;
    logic [7:0] glitch_cnt;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int exp_q[$];

    rpm_pulse_cond #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .STALL_CYCLES    (100),
        .EDGE            (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sensor_in  (sensor_in),
        .en         (en),
        .pulse      (pulse),
        .level      (level),
        .stalled    (stalled),
        .glitch_cnt (glitch_cnt)
    );

    always #500 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // A rising edge driven now must pulse 7 negedges later: sampled at the
    // next posedge, plus 2 sync stages and 4 debounce cycles.
    task automatic rise_expect();
        sensor_in = 1'b1;
        exp_q.push_back(cyc + 7);
    endtask

    // Monitor: every observed pulse must match the oldest expected cycle.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && pulse === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                chk("pulse_cycle", 32'(cyc), 32'(exp_q.pop_front()));
                chk("pulse_level", 32'(level), 32'd1);
                chk("pulse_stalled", 32'(stalled), 32'd0);
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        sensor_in = 1'b0;
        en        = 1'b1;

        // Reset with sensor toggling: all outputs held at 0.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sensor_in = ~sensor_in;
        end
        chk("reset_outputs", 32'({pulse, level, stalled, glitch_cnt}), 32'd0);
        sensor_in = 1'b0;
        step(1);
        chk("reset_outputs2", 32'({pulse, level, stalled, glitch_cnt}), 32'd0);
        reset_n = 1'b1;

        // Stall with no edges: stalled rises on cycle 100 and holds.
        step(99);
        chk("stall_before", 32'(stalled), 32'd0);
        step(1);
        chk("stall_at_100", 32'(stalled), 32'd1);
        step(50);
        chk("stall_hold", 32'(stalled), 32'd1);
        chk("idle_level", 32'(level), 32'd0);

        // Clean rising edge pulses once and clears stall; falling edge is silent.
        rise_expect();
        step(20);
        chk("clean_level_hi", 32'(level), 32'd1);
        sensor_in = 1'b0;
        step(20);
        chk("clean_level_lo", 32'(level), 32'd0);

        // en=0 across an accepted rising edge: level tracks, no pulse.
        en = 1'b0;
        sensor_in = 1'b1;
        step(20);
        chk("en0_level", 32'(level), 32'd1);
        chk("en0_stalled", 32'(stalled), 32'd0);
        en = 1'b1;
        step(20);
        sensor_in = 1'b0;
        step(20);
        rise_expect();
        step(20);
        sensor_in = 1'b0;
        step(20);

        // Reset pulse while qualifying a rising edge.
        sensor_in = 1'b1;
        step(3);
        reset_n   = 1'b0;
        sensor_in = 1'b0;
        step(2);
        chk("midqual_reset", 32'({pulse, level, stalled, glitch_cnt}), 32'd0);
        reset_n = 1'b1;
        step(20);
        chk("midqual_level", 32'(level), 32'd0);
        chk("midqual_glitch", 32'(glitch_cnt), 32'd0);

        // Periodic square wave, period 48.
        for (int i = 0; i < 50; i++) begin
            rise_expect();
            step(24);
            sensor_in = 1'b0;
            step(24);
        end
        step(20);
        chk("periodic_glitch", 32'(glitch_cnt), 32'd0);

        // 3-cycle spikes are rejected and counted.
        for (int i = 0; i < 10; i++) begin
            sensor_in = 1'b1;
            step(3);
            sensor_in = 1'b0;
            step(5);
        end
        chk("glitch_10", 32'(glitch_cnt), 32'd10);
        chk("glitch_level", 32'(level), 32'd0);
        for (int i = 0; i < 300; i++) begin
            sensor_in = 1'b1;
            step(3);
            sensor_in = 1'b0;
            step(3);
        end
        step(5);
        chk("glitch_sat", 32'(glitch_cnt), 32'd255);
        sensor_in = 1'b1;
        step(3);
        sensor_in = 1'b0;
        step(8);
        chk("glitch_hold", 32'(glitch_cnt), 32'd255);

        chk("pulses_missing", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
